// File: rtl/mul_iter.sv
// Iterative shift-add multiplier: retires STEP multiplier bits per cycle, start/done handshake with cancel.
// Optional early termination on an exhausted multiplier is enabled by defining MUL_ITER_EARLY_TERM_EN.
module mul_iter #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned STEP  = 1
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 start,
    input  logic                 cancel,
    input  logic                 signed_op,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   result
);

    localparam int unsigned ITERS = WIDTH / STEP;
    localparam int unsigned CNT_W = $clog2(ITERS + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;

    logic [2*WIDTH-1:0]   r_mcand;
    logic [2*WIDTH-1:0]   r_acc;
    logic [2*WIDTH-1:0]   r_result;
    logic [WIDTH-1:0]     r_mplier;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_neg;

    logic [2*WIDTH-1:0]   w_pp;
    logic [2*WIDTH-1:0]   w_final;
    logic [WIDTH-1:0]     w_mplier_nxt;
    logic [WIDTH-1:0]     w_abs_a;
    logic [WIDTH-1:0]     w_abs_b;
    logic                 w_accept;
    logic                 w_last;
    logic                 w_finish;

    // -(2^(WIDTH-1)) wraps to itself, which is the correct unsigned magnitude.
    assign w_abs_a      = (signed_op && a[WIDTH-1]) ? (-a) : a;
    assign w_abs_b      = (signed_op && b[WIDTH-1]) ? (-b) : b;
    assign w_mplier_nxt = r_mplier >> STEP;
    assign w_final      = r_neg ? (-r_acc) : r_acc;
    assign w_accept     = (r_state == S_IDLE) && start && !cancel;
    assign w_finish     = (r_state == S_DONE) && !cancel;

`ifdef MUL_ITER_EARLY_TERM_EN
    assign w_last = (r_cnt == CNT_W'(1)) || (w_mplier_nxt == '0);
`else
    assign w_last = (r_cnt == CNT_W'(1));
`endif

    always_comb begin
        w_pp = '0;
        for (int unsigned i = 0; i < STEP; i++) begin
            if (r_mplier[i]) begin
                w_pp = w_pp + (r_mcand << i);
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        busy        = (r_state != S_IDLE);
        done        = w_finish;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = S_CALC;
                end
            end
            S_CALC: begin
                if (cancel) begin
                    w_state_nxt = S_IDLE;
                end else if (w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // The product is visible in the DONE cycle itself but only committed if not cancelled there.
    assign result = w_finish ? w_final : r_result;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_mcand  <= '0;
            r_acc    <= '0;
            r_result <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
            r_neg    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_mcand  <= {{WIDTH{1'b0}}, w_abs_a};
                r_mplier <= w_abs_b;
                r_neg    <= signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
                r_acc    <= '0;
                r_cnt    <= CNT_W'(ITERS);
            end else if ((r_state == S_CALC) && !cancel) begin
                r_acc    <= r_acc + w_pp;
                r_mcand  <= r_mcand << STEP;
                r_mplier <= w_mplier_nxt;
                r_cnt    <= r_cnt - CNT_W'(1);
            end
            if (w_finish) begin
                r_result <= w_final;
            end
        end
    end

endmodule

// File: tb/tb_mul_iter.sv
// Directed self-checking bench for mul_iter: STEP=1 and STEP=4 instances driven in lockstep.
// Latency expectations follow MUL_ITER_EARLY_TERM_EN when it is defined.
module tb_mul_iter;

`ifdef MUL_ITER_EARLY_TERM_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic        clk;
    logic        resetn;
    logic        start;
    logic        cancel;
    logic        signed_op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy1, done1, busy4, done4;
    logic [63:0] result1, result4;

    int n_pass  = 0;
    int n_total = 0;

    mul_iter #(.WIDTH(32), .STEP(1)) u_dut1 (
        .clk(clk), .resetn(resetn), .start(start), .cancel(cancel), .signed_op(signed_op),
        .a(a), .b(b), .busy(busy1), .done(done1), .result(result1)
    );

    mul_iter #(.WIDTH(32), .STEP(4)) u_dut4 (
        .clk(clk), .resetn(resetn), .start(start), .cancel(cancel), .signed_op(signed_op),
        .a(a), .b(b), .busy(busy4), .done(done4), .result(result4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sgn;
        logic [63:0] prod;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int exp_lat(input logic [31:0] bb, input logic sgn, input int step);
        logic [31:0] m;
        int n;
        int it;
        m = (sgn && bb[31]) ? -bb : bb;
        n = 0;
        for (int i = 0; i < 32; i++) begin
            if (m[i]) n = i + 1;
        end
        it = (n + step - 1) / step;
        if (it < 1) it = 1;
        return EARLY ? (it + 1) : (32 / step + 1);
    endfunction

    task automatic run_op(input logic [31:0] ia, input logic [31:0] ib, input logic isg,
                          input logic [63:0] exp, input string tag);
        int lat1 = 0;
        int lat4 = 0;
        logic [63:0] r1 = '0;
        logic [63:0] r4 = '0;
        a = ia; b = ib; signed_op = isg; start = 1'b1;
        for (int c = 1; c <= 45; c++) begin
            @(posedge clk); #1;
            if (c == 1) begin
                start = 1'b0;
                chk({tag, " busy@1"}, {62'd0, busy1, busy4}, 64'd3);
            end
            if (done1 && lat1 == 0) begin lat1 = c; r1 = result1; end
            if (done4 && lat4 == 0) begin lat4 = c; r4 = result4; end
            if (lat1 != 0 && lat4 != 0) break;
        end
        chk({tag, " res s1"}, r1, exp);
        chk({tag, " lat s1"}, 64'(lat1), 64'(exp_lat(ib, isg, 1)));
        chk({tag, " res s4"}, r4, exp);
        chk({tag, " lat s4"}, 64'(lat4), 64'(exp_lat(ib, isg, 4)));
        @(posedge clk); #1;
        chk({tag, " idle after"}, {60'd0, busy1, busy4, done1, done4}, 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [63:0] prev;
        int          seen;
        int          ndone;

        vecs[0]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFE00000001};
        vecs[1]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 64'h0000000000000001};
        vecs[2]  = '{32'h80000000, 32'h80000000, 1'b1, 64'h4000000000000000};
        vecs[3]  = '{32'h00000003, 32'hFFFFFFFB, 1'b1, 64'hFFFFFFFFFFFFFFF1};
        vecs[4]  = '{32'h00000000, 32'h12345678, 1'b0, 64'h0000000000000000};
        vecs[5]  = '{32'h00000000, 32'hFFFFFFFF, 1'b1, 64'h0000000000000000};
        vecs[6]  = '{32'h80000000, 32'h80000000, 1'b0, 64'h4000000000000000};
        vecs[7]  = '{32'h80000000, 32'h00000001, 1'b1, 64'hFFFFFFFF80000000};
        vecs[8]  = '{32'h12345678, 32'h00000001, 1'b0, 64'h0000000012345678};
        vecs[9]  = '{32'h7FFFFFFF, 32'h7FFFFFFF, 1'b1, 64'h3FFFFFFF00000001};
        vecs[10] = '{32'h0000FFFF, 32'h00010001, 1'b0, 64'h00000000FFFFFFFF};
        vecs[11] = '{32'hFFFFFFFE, 32'h00000005, 1'b1, 64'hFFFFFFFFFFFFFFF6};
        vecs[12] = '{32'h12345678, 32'h9ABCDEF0, 1'b0, 64'h0B00EA4E242D2080};

        resetn = 1'b0; start = 1'b0; cancel = 1'b0; signed_op = 1'b0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset flags", {60'd0, busy1, done1, busy4, done4}, 64'd0);
        chk("reset result s1", result1, 64'd0);
        chk("reset result s4", result4, 64'd0);
        resetn = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 13; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].sgn, vecs[i].prod, $sformatf("vec%0d", i));
        end

        // Cancel mid-CALC on the STEP=1 unit, then restart one cycle later.
        prev = result1;
        a = 32'd5; b = 32'h80000003; signed_op = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        cancel = 1'b1;
        #1;
        chk("cancel calc done", {63'd0, done1}, 64'd0);
        @(posedge clk); #1;
        cancel = 1'b0;
        chk("cancel calc busy", {63'd0, busy1}, 64'd0);
        chk("cancel calc result", result1, prev);
        run_op(32'd5, 32'h80000003, 1'b0, 64'h000000028000000F, "restart");

        // Cancel in the DONE cycle suppresses the pulse and the result update.
        prev = result1;
        a = 32'd3; b = 32'd3; signed_op = 1'b0; start = 1'b1;
        seen = 0;
        for (int c = 1; c <= 45; c++) begin
            @(posedge clk); #1;
            if (c == 1) start = 1'b0;
            if (done1) begin
                seen = 1;
                cancel = 1'b1;
                #1;
                chk("cancel done pulse", {63'd0, done1}, 64'd0);
                chk("cancel done result", result1, prev);
                break;
            end
        end
        chk("cancel done reached", 64'(seen), 64'd1);
        @(posedge clk); #1;
        cancel = 1'b0;
        chk("cancel done busy", {63'd0, busy1}, 64'd0);
        chk("cancel done held", result1, prev);

        // Cancel has priority over start in IDLE.
        a = 32'd9; b = 32'd9; start = 1'b1; cancel = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; cancel = 1'b0;
        chk("idle cancel busy", {62'd0, busy1, busy4}, 64'd0);
        ndone = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done1 || done4 || busy1 || busy4) ndone++;
        end
        chk("idle cancel quiet", 64'(ndone), 64'd0);

        // start held through the operation with a changing operand is ignored.
        a = 32'h00001234; b = 32'h00000010; signed_op = 1'b0; start = 1'b1;
        seen = 0;
        for (int c = 1; c <= 45; c++) begin
            @(posedge clk); #1;
            a = 32'h0000FFFF;
            if (done1) begin
                seen = 1;
                chk("held start result", result1, 64'h0000000000012340);
                break;
            end
        end
        chk("held start done", 64'(seen), 64'd1);
        @(posedge clk); #1;
        chk("start in done ignored", {63'd0, busy1}, 64'd0);
        start = 1'b0;
        repeat (12) begin @(posedge clk); #1; end

        // Asynchronous reset in the middle of CALC.
        a = 32'd7; b = 32'h80000001; signed_op = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        resetn = 1'b0;
        #1;
        chk("async rst flags", {60'd0, busy1, done1, busy4, done4}, 64'd0);
        chk("async rst result s1", result1, 64'd0);
        chk("async rst result s4", result4, 64'd0);
        #3;
        resetn = 1'b1;
        @(posedge clk); #1;
        chk("post rst idle", {62'd0, busy1, busy4}, 64'd0);
        run_op(32'd6, 32'd7, 1'b0, 64'd42, "post rst");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
